pcounter_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `pcounter` increment datapath among `NUM_REQ` requesters. It accepts one 40-bit request at a time and drives it onto the datapath's `data_in`. It captures `data_out` (`data_in + 1`) and returns the result tagged with the requester index over a valid/ready response port. It sits between the requester blocks and a single `pcounter` instance; `clk` and `rst` are shared with that instance.

---
 rtl/pcounter_arb.sv | 124 ++++++++++++
 tb/tb_pcounter_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcounter_arb.sv
// Round-robin arbiter/sequencer sharing one pcounter (data_in + 1) datapath among NUM_REQ requesters.
// Optional build macro PCOUNTER_ARB_PRIO_EN: requester 0 gets fixed top priority, 1..NUM_REQ-1 round-robin.
module pcounter_arb #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 40,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [DW-1:0]         rsp_data,
  output logic [DW-1:0]         dp_data_in,
  input  logic [DW-1:0]         dp_data_out,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and rsp_* stay stable while rsp_valid is high and rsp_ready low.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [IDW-1:0]     ptr, ptr_nx, id_q;
  logic [IDW-1:0]     win_idx;
  logic               win_found;
  logic [NUM_REQ-1:0] cand;
  logic [IDW:0]       sum;
  logic [DW-1:0]      win_data;

  // Scan from ptr upward with wrap; the extra sum bit keeps non-power-of-two NUM_REQ correct.
  always_comb begin
    cand      = req_valid;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
`ifdef PCOUNTER_ARB_PRIO_EN
    cand[0]   = 1'b0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      if (!win_found && cand[sum[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[IDW-1:0];
      end
    end
`ifdef PCOUNTER_ARB_PRIO_EN
    if (req_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDW'(i)) win_data = req_data[i*DW +: DW];
    end
  end

  always_comb begin
    if (id_q == IDW'(NUM_REQ-1)) ptr_nx = '0;
    else                         ptr_nx = id_q + IDW'(1);
`ifdef PCOUNTER_ARB_PRIO_EN
    if (id_q == '0) ptr_nx = ptr;
`endif
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_nx  = ISSUE;
          req_ready = NUM_REQ'(1) << win_idx;
        end
      end
      ISSUE:   state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      id_q       <= '0;
      dp_data_in <= '0;
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && win_found) begin
        dp_data_in <= win_data;
        id_q       <= win_idx;
      end
      // pcounter samples dp_data_in on the falling edge of ISSUE, so its output is settled here.
      if (state == ISSUE) begin
        rsp_data <= dp_data_out;
        rsp_id   <= id_q;
      end
      if (state == RESP && rsp_ready) ptr <= ptr_nx;
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_pcounter_arb.sv
// Bench for pcounter_arb: transaction-level reference model (pending-response queue with due cycles)
// checked every cycle, plus directed scenarios and randomized traffic.
module tb_pcounter_arb;
  localparam int N   = 4;
  localparam int DW  = 40;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [DW-1:0]     rsp_data;
  logic [DW-1:0]     dp_data_in;
  logic [DW-1:0]     dp_data_out;
  logic              busy;
  logic [1:0]        dbg_state;

  pcounter_arb #(.NUM_REQ(N), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .dp_data_in(dp_data_in), .dp_data_out(dp_data_out),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // the shared pcounter: samples on the falling edge, returns data_in + 1
  always @(negedge clk) dp_data_out <= dp_data_in + 40'd1;

  // scoreboard
  int                    n_vec = 0;
  int                    n_err = 0;
  int                    cyc   = 0;
  bit                    known = 1'b0;
  int                    m_ptr = 0;
  logic [DW-1:0]         m_dp = '0;
  logic [DW-1:0]         m_rsp_data = '0;
  logic [IDW-1:0]        m_rsp_id = '0;
  logic [IDW+DW-1:0]     exp_q[$];
  int                    due_q[$];

  bit                    log_en = 1'b0;
  logic [IDW-1:0]        got_ids[$];

  always @(posedge clk) begin
    if (log_en && !rst && rsp_valid && rsp_ready) got_ids.push_back(rsp_id);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v_in, input int p);
    logic [N-1:0] v;
    logic [N-1:0] t;
    int i;
    v = v_in;
`ifdef PCOUNTER_ARB_PRIO_EN
    if (v[0]) return 0;
    v[0] = 1'b0;
`endif
    for (int k = 0; k < N; k++) begin
      i = (p + k) % N;
      t = v >> i;
      if (t[0]) return i;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] slice_of(input logic [N*DW-1:0] d, input int i);
    logic [N*DW-1:0] sh;
    sh = d >> (i * DW);
    return sh[DW-1:0];
  endfunction

  // driver tasks
  task automatic set_data(input int i, input logic [DW-1:0] v);
    logic [N*DW-1:0] mask;
    mask = (N*DW)'({DW{1'b1}}) << (i * DW);
    req_data = (req_data & ~mask) | (((N*DW)'(v)) << (i * DW));
  endtask

  // Compares one cycle against the model, advances the model across the edge, waits for it.
  task automatic step();
    int               w;
    int               hid;
    logic [N-1:0]     exp_rdy;
    bit               exp_v;
    logic [DW-1:0]    op;
    logic [63:0]      res;
    logic [IDW+DW-1:0] head;
    #1;
    w       = -1;
    exp_rdy = '0;
    exp_v   = (due_q.size() != 0) && (cyc >= due_q[0]);
    if (known && !rst && exp_q.size() == 0) w = pick(req_valid, m_ptr);
    if (w >= 0) exp_rdy = N'(1) << w;
    if (known) begin
      check("req_ready",  64'(req_ready),  64'(exp_rdy));
      check("rsp_valid",  64'(rsp_valid),  64'(exp_v));
      check("busy",       64'(busy),       64'(exp_q.size() != 0));
      check("rsp_data",   64'(rsp_data),   64'(m_rsp_data));
      check("rsp_id",     64'(rsp_id),     64'(m_rsp_id));
      check("dp_data_in", 64'(dp_data_in), 64'(m_dp));
    end
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      m_ptr      = 0;
      m_dp       = '0;
      m_rsp_data = '0;
      m_rsp_id   = '0;
      known      = 1'b1;
    end else if (known) begin
      if (w >= 0) begin
        op  = slice_of(req_data, w);
        res = (64'(op) + 64'd1) % (64'd1 << DW);
        exp_q.push_back({IDW'(w), DW'(res)});
        due_q.push_back(cyc + 2);
        m_dp = op;
      end else if (exp_v && rsp_ready) begin
        head = exp_q.pop_front();
        void'(due_q.pop_front());
        hid  = int'(head[IDW+DW-1:DW]);
`ifdef PCOUNTER_ARB_PRIO_EN
        if (hid != 0) m_ptr = (hid + 1) % N;
`else
        m_ptr = (hid + 1) % N;
`endif
      end
      if (due_q.size() != 0 && due_q[0] == cyc + 1) begin
        m_rsp_id   = exp_q[0][IDW+DW-1:DW];
        m_rsp_data = exp_q[0][DW-1:0];
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int exp_fair[5] = '{0, 1, 2, 3, 0};
  int exp_prio[4];

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // single request on requester 2
    set_data(2, 40'h00_0000_0010);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    repeat (4) step();

    // wrap on requester 0
    set_data(0, 40'hFF_FFFF_FFFF);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (4) step();

    // fairness: all four held, ptr starts from 0 after reset
    pulse_reset();
    for (int i = 0; i < N; i++) set_data(i, DW'(10 * (i + 1)));
    got_ids.delete();
    log_en    = 1'b1;
    req_valid = 4'hF;
    repeat (16) step();
    log_en    = 1'b0;
    req_valid = '0;
    repeat (4) step();
    check("fair_count", 64'(got_ids.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < got_ids.size()) check("fair_id", 64'(got_ids[i]), 64'(exp_fair[i]));
    end

    // backpressure with other requesters waiting
    set_data(1, 40'h00_0000_1234);
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1001;
    rsp_ready = 1'b0;
    repeat (12) step();
    rsp_ready = 1'b1;
    repeat (2) step();
    req_valid = '0;
    repeat (8) step();

    // reset while in ISSUE, then everyone requests: requester 0 must win
    set_data(2, 40'h00_0000_0777);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    pulse_reset();
    repeat (2) step();
    req_valid = 4'hF;
    step();
    req_valid = '0;
    repeat (4) step();

    // requesters 0 and 1 held valid
    pulse_reset();
    set_data(0, 40'h00_0000_0100);
    set_data(1, 40'h00_0000_0200);
    got_ids.delete();
    log_en    = 1'b1;
    req_valid = 4'b0011;
    repeat (20) step();
    log_en    = 1'b0;
    req_valid = '0;
    repeat (4) step();
`ifdef PCOUNTER_ARB_PRIO_EN
    exp_prio = '{0, 0, 0, 0};
`else
    exp_prio = '{0, 1, 0, 1};
`endif
    check("prio_count", 64'(got_ids.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < got_ids.size()) check("prio_id", 64'(got_ids[i]), 64'(exp_prio[i]));
    end

    // randomized traffic with occasional reset and backpressure
    for (int n = 0; n < 600; n++) begin
      req_valid = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) set_data(i, {DW{1'b1}});
        else                           set_data(i, DW'({$urandom(), $urandom()}));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
